hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised forwarding and interlock unit for the Minisys-1A pipeline. For NSRC decode-stage source operands it selects the newest in-flight copy of each value across NSTAGE downstream pipeline stages, and raises a stall on load-use hazards. It also tracks the multi-cycle multiply/divide unit with a latency counter, interlocks every HI/LO access while that unit is busy, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- NSRC, 2, number of source operands checked per cycle
- NSTAGE, 3, number of forwarding stages; index 0 = youngest (EX), NSTAGE-1 = oldest (WB)
- MD_LAT, 32, mul/div latency in cycles, >=1
- CNT_W, 32, stall counter width
- SW (derived), clog2(NSTAGE+2), select width per source

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- src_addr  in  NSRC*5  register address per source (slice i = [i*5+:5])
- src_use  in  NSRC  source i is actually read this cycle
- src_mfhi  in  NSRC  source i reads HI (overrides src_addr)
- src_mflo  in  NSRC  source i reads LO (overrides src_addr)
- id_mthilo  in  1  decode instruction writes HI/LO (mthi/mtlo/mult/div)
- stg_regwrite  in  NSTAGE  stage k writes the GPR file
- stg_waddr  in  NSTAGE*5  destination register of stage k
- stg_ready  in  NSTAGE  stage k result is available; 0 for a load in EX
- stg_mthi  in  NSTAGE  stage k writes HI
- stg_mtlo  in  NSTAGE  stage k writes LO
- md_start  in  1  mul/div issues this cycle (honoured only when stall=0)
- md_flush  in  1  cancel in-flight mul/div (exception)
- fwd_sel  out  NSRC*SW  0 = register file; k+1 = stage k; NSTAGE+1 = mul/div result
- stall  out  1  freeze fetch/decode, bubble into EX
- md_busy  out  1  mul/div in flight
- md_done  out  1  mul/div result valid this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- GPR match for source i, stage k: src_use[i] & !src_mfhi[i] & !src_mflo[i] & stg_regwrite[k] & stg_waddr[k]==src_addr[i] & src_addr[i]!=0. $zero is never forwarded.
- HI match: src_use[i] & src_mfhi[i] & stg_mthi[k]. LO match uses src_mflo and stg_mtlo the same way.
- fwd_sel[i] = k+1 for the lowest matching k (youngest stage wins).
- With no stage match, a HI/LO read during a md_done cycle selects NSTAGE+1. Otherwise fwd_sel[i] is 0.
- Load-use: stall whenever the selected stage k has stg_ready[k]=0. An older ready match does not cancel this stall.
- Mul/div interlock: stall when (md_busy & !md_done) and any of the following holds:
  - any used source reads HI/LO;
  - id_mthilo=1;
  - md_start=1.
- stall is the OR of all hazard terms. fwd_sel is still driven while stall=1.
- Counter md_cnt is CLOG2(MD_LAT+1) bits wide.
  - md_start & !stall loads md_cnt=MD_LAT and sets busy.
  - While md_cnt>0 it decrements each cycle.
  - md_busy = md_cnt!=0; md_done = md_cnt==1.
- md_flush clears md_cnt to 0 on the next edge and takes priority over md_start. md_done is not raised for a flushed operation.
- md_start during a md_done cycle is legal and does not stall. The counter reloads and md_busy stays high without a gap.
- stall_cnt increments on each edge where stall=1. It holds at all-ones and never wraps.

## Timing
- fwd_sel and stall are combinational from current-cycle inputs and registered state. There is no added latency.
- md_start accepted at edge 0 gives md_busy=1 in cycles 1..MD_LAT and md_done=1 in cycle MD_LAT only. With MD_LAT=1, busy and done are both high in cycle 1 only.
- Reset values: md_cnt=0, md_busy=0, md_done=0, stall_cnt=0. With src_use=0, fwd_sel=0 and stall=0.
- Reset asserted mid-operation clears md_cnt and stall_cnt immediately (asynchronously). No md_done follows.
- stall_cnt reflects stall cycles up to and including the previous edge.

## Test plan
- Forwarding priority:
  - Stimulus: src_addr[0]=5 with stages 0 and 2 writing r5, all ready. Required: fwd_sel[0]=1, stall=0.
  - Stimulus: src_addr[1]=0 with stage 0 writing r0. Required: fwd_sel[1]=0.
- Load-use: stage 0 writes r7 with stg_ready[0]=0, stage 1 also writes r7, src_addr[0]=7. Required: fwd_sel[0]=1, stall=1. The next cycle with stg_ready[0]=1 gives stall=0.
- Divide interlock:
  - Stimulus: MD_LAT=4, md_start at edge 0, then src_mflo[0] held. Required: stall=1 in cycles 1-3; cycle 4 has md_done=1, stall=0, fwd_sel[0]=NSTAGE+1; cycle 5 has md_busy=0.
  - Required: stall_cnt=3 after cycle 4.
- Back-to-back: md_start again in the md_done cycle. Required: md_busy stays high continuously and md_done next pulses 4 cycles later.
- Flush/reset: md_flush in cycle 2 of a divide. Required: md_busy=0 from cycle 3 with no md_done. Asserting reset mid-divide clears md_busy and stall_cnt immediately.
- Saturation: CNT_W=3, stall held for 10 cycles. Required: stall_cnt=7 and it stays at 7.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/pipeline side bundle for the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int NSRC   = 2,
  parameter int NSTAGE = 3,
  parameter int CNT_W  = 32
);
  localparam int SW = $clog2(NSTAGE + 2);

  logic [NSRC*5-1:0]   src_addr;
  logic [NSRC-1:0]     src_use;
  logic [NSRC-1:0]     src_mfhi;
  logic [NSRC-1:0]     src_mflo;
  logic                id_mthilo;
  logic [NSTAGE-1:0]   stg_regwrite;
  logic [NSTAGE*5-1:0] stg_waddr;
  logic [NSTAGE-1:0]   stg_ready;
  logic [NSTAGE-1:0]   stg_mthi;
  logic [NSTAGE-1:0]   stg_mtlo;
  logic                md_start;
  logic                md_flush;
  logic [NSRC*SW-1:0]  fwd_sel;
  logic                stall;
  logic                md_busy;
  logic                md_done;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output src_addr, src_use, src_mfhi, src_mflo, id_mthilo,
    output stg_regwrite, stg_waddr, stg_ready, stg_mthi, stg_mtlo,
    output md_start, md_flush,
    input  fwd_sel, stall, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  src_addr, src_use, src_mfhi, src_mflo, id_mthilo,
    input  stg_regwrite, stg_waddr, stg_ready, stg_mthi, stg_mtlo,
    input  md_start, md_flush,
    output fwd_sel, stall, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - operand forwarding select, load-use and mul/div interlock
module hazard_scoreboard #(
  parameter int NSRC   = 2,
  parameter int NSTAGE = 3,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  hazard_scoreboard_if.slave hz
);
  localparam int SW  = $clog2(NSTAGE + 2);
  localparam int MDW = $clog2(MD_LAT + 1);

  logic [MDW-1:0]     md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               md_busy, md_done;
  logic [NSRC*SW-1:0] fwd_sel;
  logic               load_stall, hilo_read, md_stall, stall;
  logic [SW-1:0]      sel;
  logic               hit, rdy, reads_hilo;

  assign md_busy = (md_cnt_q != '0);
  assign md_done = (md_cnt_q == MDW'(1));

  // Per source: scan oldest to youngest so the youngest matching stage overrides
  always_comb begin
    fwd_sel    = '0;
    load_stall = 1'b0;
    hilo_read  = 1'b0;
    sel        = '0;
    hit        = 1'b0;
    rdy        = 1'b1;
    reads_hilo = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      sel        = '0;
      hit        = 1'b0;
      rdy        = 1'b1;
      reads_hilo = hz.src_use[i] & (hz.src_mfhi[i] | hz.src_mflo[i]);
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if ((hz.src_use[i] & ~hz.src_mfhi[i] & ~hz.src_mflo[i] & hz.stg_regwrite[k]
             & (hz.stg_waddr[k*5 +: 5] == hz.src_addr[i*5 +: 5])
             & (hz.src_addr[i*5 +: 5] != 5'd0))
            | (hz.src_use[i] & hz.src_mfhi[i] & hz.stg_mthi[k])
            | (hz.src_use[i] & hz.src_mflo[i] & hz.stg_mtlo[k])) begin
          sel = SW'(k + 1);
          hit = 1'b1;
          rdy = hz.stg_ready[k];
        end
      end
      // A pipeline copy of HI/LO is newer than the mul/div result, so it only wins with no stage hit
      if (!hit && reads_hilo && md_done) begin
        sel = SW'(NSTAGE + 1);
      end
      // Only the selected (youngest) copy matters; an older ready copy is stale
      if (hit && !rdy) begin
        load_stall = 1'b1;
      end
      if (reads_hilo) begin
        hilo_read = 1'b1;
      end
      fwd_sel[i*SW +: SW] = sel;
    end
  end

  assign md_stall = md_busy & ~md_done & (hilo_read | hz.id_mthilo | hz.md_start);
  assign stall    = load_stall | md_stall;

  // Mul/div latency counter and saturating stall counter next state
  always_comb begin
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (hz.md_flush) begin
      md_cnt_d = '0;
    end else if (hz.md_start && !stall) begin
      md_cnt_d = MDW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MDW'(1);
    end
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers, cleared immediately on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.fwd_sel   = fwd_sel;
  assign hz.stall     = stall;
  assign hz.md_busy   = md_busy;
  assign hz.md_done   = md_done;
  assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;
  localparam int NSRC   = 2;
  localparam int NSTAGE = 3;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 3;
  localparam int SW     = 3;

  typedef struct {
    string              name;
    logic [NSRC*SW-1:0] fwd;
    logic               stall;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   wait_cyc = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NSRC(NSRC), .NSTAGE(NSTAGE), .CNT_W(CNT_W)) hz();

  hazard_scoreboard #(.NSRC(NSRC), .NSTAGE(NSTAGE), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clock (clk),
    .reset (rst),
    .hz    (hz)
  );

  task automatic idle();
    hz.src_addr     = '0;
    hz.src_use      = '0;
    hz.src_mfhi     = '0;
    hz.src_mflo     = '0;
    hz.id_mthilo    = 1'b0;
    hz.stg_regwrite = '0;
    hz.stg_waddr    = '0;
    hz.stg_ready    = '1;
    hz.stg_mthi     = '0;
    hz.stg_mtlo     = '0;
    hz.md_start     = 1'b0;
    hz.md_flush     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_out(input string name, input int f0, input int f1,
                            input logic st, input logic bz, input logic dn, input int cnt);
    exp_t x;
    x.name  = name;
    x.fwd   = {SW'(f1), SW'(f0)};
    x.stall = st;
    x.busy  = bz;
    x.done  = dn;
    x.cnt   = CNT_W'(cnt);
    q.push_back(x);
  endtask

  task automatic load_use_inputs(input logic rdy0);
    hz.src_use      = 2'b01;
    hz.src_addr     = {5'd0, 5'd7};
    hz.stg_regwrite = 3'b011;
    hz.stg_waddr    = {5'd0, 5'd7, 5'd7};
    hz.stg_ready    = {2'b11, rdy0};
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (q.size() > 0) begin
          e = q.pop_front();
          total++;
          if ({hz.fwd_sel, hz.stall, hz.md_busy, hz.md_done, hz.stall_cnt} !==
              {e.fwd, e.stall, e.busy, e.done, e.cnt}) begin
            bad++;
            $display("FAIL %s: got fwd=%h stall=%b busy=%b done=%b cnt=%0d, want fwd=%h stall=%b busy=%b done=%b cnt=%0d",
                     e.name, hz.fwd_sel, hz.stall, hz.md_busy, hz.md_done, hz.stall_cnt,
                     e.fwd, e.stall, e.busy, e.done, e.cnt);
          end
        end
      end
    join_none

    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    tick(); rst = 1'b0;

    // Forwarding priority and qualifiers
    tick();
    hz.src_use = 2'b01; hz.src_addr = {5'd0, 5'd5};
    hz.stg_regwrite = 3'b101; hz.stg_waddr = {5'd5, 5'd9, 5'd5};
    expect_out("fwd_young", 1, 0, 0, 0, 0, 0);
    tick();
    hz.src_use = 2'b10; hz.src_addr = '0;
    hz.stg_regwrite = 3'b001; hz.stg_waddr = '0;
    expect_out("fwd_zero", 0, 0, 0, 0, 0, 0);
    tick();
    hz.src_use = 2'b11; hz.src_addr = {5'd3, 5'd3}; hz.src_mfhi = 2'b10;
    hz.stg_regwrite = 3'b010; hz.stg_waddr = {5'd0, 5'd3, 5'd0}; hz.stg_mthi = 3'b100;
    expect_out("fwd_hi", 2, 3, 0, 0, 0, 0);
    tick();
    hz.src_use = 2'b00; hz.src_addr = {5'd3, 5'd3};
    hz.stg_regwrite = 3'b111; hz.stg_waddr = {5'd3, 5'd3, 5'd3}; hz.stg_ready = 3'b000;
    expect_out("fwd_unused", 0, 0, 0, 0, 0, 0);

    // Load-use
    tick(); load_use_inputs(1'b0);
    expect_out("load_use", 1, 0, 1, 0, 0, 0);
    tick(); load_use_inputs(1'b1);
    expect_out("load_use_clear", 1, 0, 0, 0, 0, 1);

    // Asynchronous reset clears the stall counter within the cycle
    tick(); rst = 1'b1;
    expect_out("reset_clear", 0, 0, 0, 0, 0, 0);
    tick(); rst = 1'b0;
    expect_out("post_reset", 0, 0, 0, 0, 0, 0);

    // Divide with LO read interlock
    tick(); hz.md_start = 1'b1;
    expect_out("div_start", 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      tick(); hz.src_use = 2'b01; hz.src_mflo = 2'b01;
      expect_out("div_stall", 0, 0, 1, 1, 0, c - 1);
    end
    tick(); hz.src_use = 2'b01; hz.src_mflo = 2'b01;
    expect_out("div_done", 4, 0, 0, 1, 1, 3);
    tick(); hz.src_use = 2'b01; hz.src_mflo = 2'b01;
    expect_out("div_idle", 0, 0, 0, 0, 0, 3);

    // Back-to-back, plus start and mthilo interlocks while busy
    tick(); hz.md_start = 1'b1;
    expect_out("b2b_start", 0, 0, 0, 0, 0, 3);
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_out("b2b_busy", 0, 0, 0, 1, 0, 3);
    end
    tick(); hz.md_start = 1'b1;
    expect_out("b2b_restart", 0, 0, 0, 1, 1, 3);
    tick();
    expect_out("b2b_gapless", 0, 0, 0, 1, 0, 3);
    tick(); hz.md_start = 1'b1;
    expect_out("start_busy_stall", 0, 0, 1, 1, 0, 3);
    tick(); hz.id_mthilo = 1'b1;
    expect_out("mthilo_stall", 0, 0, 1, 1, 0, 4);
    tick();
    expect_out("b2b_done", 0, 0, 0, 1, 1, 5);
    tick();
    expect_out("b2b_end", 0, 0, 0, 0, 0, 5);

    // Flush in cycle 2
    tick(); hz.md_start = 1'b1;
    expect_out("flush_start", 0, 0, 0, 0, 0, 5);
    tick();
    expect_out("flush_busy", 0, 0, 0, 1, 0, 5);
    tick(); hz.md_flush = 1'b1;
    expect_out("flush_cycle", 0, 0, 0, 1, 0, 5);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out("flush_no_done", 0, 0, 0, 0, 0, 5);
    end

    // Reset mid-divide
    tick(); hz.md_start = 1'b1;
    expect_out("rst_div_start", 0, 0, 0, 0, 0, 5);
    tick();
    expect_out("rst_div_busy", 0, 0, 0, 1, 0, 5);
    tick(); rst = 1'b1;
    expect_out("reset_mid", 0, 0, 0, 0, 0, 0);
    tick(); rst = 1'b0;
    expect_out("reset_release", 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out("reset_no_done", 0, 0, 0, 0, 0, 0);
    end

    // Saturation of the 3-bit stall counter
    for (int j = 0; j < 10; j++) begin
      tick(); load_use_inputs(1'b0);
      expect_out("sat", 1, 0, 1, 0, 0, (j < 7) ? j : 7);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      expect_out("sat_hold", 0, 0, 0, 0, 0, 7);
    end

    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
